// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// command byte with odd parity and stop bit, then check the device ACK.
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-low reset
//   send        in   transmit request, honoured only while busy=0
//   data[7:0]   in   command byte, latched when send is accepted
//   ps2_clk_in  in   raw PS2_CLK pad value (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT pad value (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
//   busy        out  transaction in progress
//   done        out  one-cycle pulse at the end of every transaction
//   err         out  one-cycle pulse with done on failure
//   err_code    out  00 ok, 01 nack, 10 timeout; held until next accept
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned RTS_CYCLES     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned MAX_IR =
        (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned MAXC =
        (TIMEOUT_CYCLES > MAX_IR) ? TIMEOUT_CYCLES : MAX_IR;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          nack_q, nack_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          clk_prev_q;
    logic          clk_s;
    logic          dat_s;
    logic          fall;
    logic          tx_bit;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = clk_prev_q & ~clk_s;

    // Frame bit sent on the fall that steps bit_q: data LSB first,
    // then parity, then the stop bit (line released).
    always_comb begin
        tx_bit = 1'b1;
        if (bit_q < 4'd8) begin
            tx_bit = data_q[bit_q[2:0]];
        end else if (bit_q == 4'd8) begin
            tx_bit = par_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b00;
            dat_sync_q <= 2'b00;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q <= clk_s;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            data_q   <= 8'h00;
            par_q    <= 1'b0;
            nack_q   <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            par_q    <= par_d;
            nack_q   <= nack_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        par_d    = par_q;
        nack_d   = nack_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (send && !busy_q) begin
                    state_d  = S_INHIBIT;
                    data_d   = data;
                    par_d    = ~^data;
                    bit_d    = 4'd0;
                    nack_d   = 1'b0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    busy_d   = 1'b1;
                    code_d   = 2'b00;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_RTS;
                    dat_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Releasing the clock hands it to the device; the start
            // bit stays driven until the first device fall.
            S_RTS: begin
                if (cnt_q == RTS_LAST) begin
                    cnt_d    = '0;
                    state_d  = S_SEND;
                    clk_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_SEND: begin
                if (fall) begin
                    cnt_d    = '0;
                    dat_oe_d = ~tx_bit;
                    if (bit_q == 4'd9) begin
                        state_d = S_ACK;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_ACK: begin
                dat_oe_d = 1'b0;
                if (fall) begin
                    cnt_d   = '0;
                    nack_d  = dat_s;
                    state_d = S_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    code_d  = nack_q ? 2'b01 : 2'b00;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A silent or stuck device ends the transaction from any
        // device-clocked state, overriding a recorded nack.
        if ((state_q == S_SEND || state_q == S_ACK ||
             state_q == S_WAIT_IDLE) &&
            !fall && cnt_q == TO_LAST &&
            !(state_q == S_WAIT_IDLE && clk_s && dat_s)) begin
            cnt_d    = '0;
            state_d  = S_IDLE;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            err_d    = 1'b1;
            code_d   = 2'b10;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, a scoreboard holds the expected outcome of every accepted send.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int RTSC = 4;
    localparam int TO   = 200;
    localparam int HALF = 10;

    typedef struct {
        logic [7:0] d;
        logic [1:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] data;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_done = 0;
    int         exp_dones = 0;
    logic [1:0] last_code = 2'b00;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTSC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .send      (send),
        .data      (data),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always @(negedge clk) begin
        if (done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // mode: 0 device acks, 1 device nacks, 2 device never clocks.
    // abort_bit > 0 pulls reset during that device clock low phase.
    task automatic run_txn(input logic [7:0] d, input int mode,
                           input bit poke, input int abort_bit);
        exp_t       e;
        exp_t       got_e;
        logic [9:0] cap;
        int         n;
        int         k;
        cap    = '0;
        e.d    = d;
        e.code = (mode == 1) ? 2'b01 : (mode == 2) ? 2'b10 : 2'b00;

        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("code_held", err_code, last_code);
        send = 1'b1;
        data = d;
        sb.push_back(e);
        @(negedge clk);
        send = 1'b0;
        data = 8'h00;
        chk("busy_rise", busy, 1);
        chk("code_clear", err_code, 0);

        n = 0;
        while (ps2_clk_oe && n < 1000) begin
            send = (poke && n == 5);
            data = send ? 8'h5A : 8'h00;
            if (n == 10) chk("inhibit_dat_oe", ps2_dat_oe, 0);
            if (n == INH + 2) chk("rts_dat_oe", ps2_dat_oe, 1);
            n++;
            @(negedge clk);
        end
        send = 1'b0;
        data = 8'h00;
        chk("clk_oe_cycles", n, INH + RTSC);
        chk("start_bit", ps2_dat_in, 0);

        if (mode == 2) begin
            k = 0;
            while (!done && k < 1000) begin
                @(negedge clk);
                k++;
            end
            chk("timeout_cycles", k, TO);
        end else begin
            repeat (HALF) @(negedge clk);
            for (int i = 1; i <= 10; i++) begin
                dev_clk_low = 1'b1;
                if (abort_bit == i) begin
                    repeat (3) @(negedge clk);
                    reset = 1'b0;
                    #1;
                    chk("rst_clk_oe", ps2_clk_oe, 0);
                    chk("rst_dat_oe", ps2_dat_oe, 0);
                    chk("rst_busy", busy, 0);
                    @(negedge clk);
                    dev_clk_low = 1'b0;
                    dev_dat_low = 1'b0;
                    void'(sb.pop_back());
                    repeat (3) @(negedge clk);
                    reset     = 1'b1;
                    last_code = 2'b00;
                    return;
                end
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                cap[i-1] = ps2_dat_in;
                repeat (HALF) @(negedge clk);
            end
            dev_dat_low = (mode == 0);
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            chk("ack_dat_oe", ps2_dat_oe, 0);
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            k = 0;
            while (k < 100) begin
                @(negedge clk);
                k++;
                if (k == 5) dev_dat_low = 1'b0;
                if (done) break;
            end
        end

        chk("done_seen", done, 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got_e = sb.pop_front();
            chk("err_code", err_code, got_e.code);
            chk("err", err, got_e.code != 2'b00);
            chk("busy_end", busy, 0);
            chk("clk_oe_end", ps2_clk_oe, 0);
            chk("dat_oe_end", ps2_dat_oe, 0);
            if (got_e.code != 2'b10)
                chk("frame", cap, {1'b1, ~^got_e.d, got_e.d});
            last_code = got_e.code;
        end
        exp_dones++;
        dev_dat_low = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        send  = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(8'hED, 0, 1'b0, 0);
        run_txn(8'h01, 0, 1'b0, 0);
        run_txn(8'hFF, 0, 1'b0, 0);
        run_txn(8'hA5, 1, 1'b0, 0);
        run_txn(8'h3C, 0, 1'b1, 0);
        run_txn(8'hAA, 2, 1'b0, 0);
        run_txn(8'h55, 0, 1'b0, 5);
        run_txn(8'hF4, 0, 1'b0, 0);

        repeat (5) @(negedge clk);
        chk("done_count", n_done, exp_dones);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the opposite direction to the keyboard_tracker receive path on the shared PS2_CLK/PS2_DAT pads.
- Sends one command byte to the keyboard (e.g. 8'hED set-LEDs, 8'hFF reset) using the standard request-to-send sequence, then checks the device ACK.
- Drives the lines open-drain through output-enables. The top level ties each pad to 1'bz when its enable is 0 and to 1'b0 when it is 1.

Parameters:
- INHIBIT_CYCLES, 6000: clock cycles PS2_CLK is held low before RTS (120 us at 50 MHz).
- RTS_CYCLES, 100: clock cycles with both lines low before PS2_CLK is released.
- TIMEOUT_CYCLES, 750000: maximum clock cycles between device clock falling edges, or waiting for idle (15 ms).

Ports:
- clock  in  1  system clock, CLOCK_50.
- reset  in  1  asynchronous, active-low. All state and outputs are cleared while it is low.
- send  in  1  request; sampled only when busy=0.
- data  in  8  command byte; latched on the cycle send is accepted.
- ps2_clk_in  in  1  raw PS2_CLK pad value (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pad value (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at the end of every transaction, pass or fail.
- err  out  1  one-cycle pulse, coincident with done, on failure.
- err_code  out  2  00 ok, 01 nack, 10 timeout. Held until the next accepted send; cleared to 00 on accept.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, err=0, err_code=00, state IDLE.
- Reset mid-transaction releases both lines immediately (asynchronously).
- Input synchronisation:
  - ps2_clk_in and ps2_dat_in each pass through 2 flops.
  - fall = (previous synced clk = 1) and (current synced clk = 0).
  - Falling edges are acted on only in SEND and ACK.
- On accept, the block latches data and computes parity = ~^data (odd parity).
- IDLE:
  - send=1 and busy=0 -> INHIBIT. busy rises the next cycle.
  - send while busy=1 is ignored.
- INHIBIT:
  - clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then -> RTS.
- RTS:
  - clk_oe=1, dat_oe=1 (start bit) for exactly RTS_CYCLES cycles, then -> SEND.
  - clk_oe is therefore high for exactly INHIBIT_CYCLES+RTS_CYCLES cycles.
- SEND:
  - clk_oe=0. Bit index 0..9 steps on each fall.
  - Falls 1-8 drive data[0]..data[7] (dat_oe = ~bit), fall 9 drives parity, fall 10 drives stop (dat_oe=0).
  - dat_oe changes the cycle after fall is detected. The device samples on PS2_CLK rising edges.
  - After fall 10 -> ACK.
- ACK:
  - dat_oe=0.
  - On fall 11, sample synced dat: 0 -> ack ok; 1 -> nack (err_code=01).
  - Either way -> WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced clk=1 and synced dat=1 on the same cycle.
  - That cycle: done=1, err=1 if nack, busy=0, -> IDLE.
  - A new send is accepted the following cycle.
- Timeout:
  - The counter clears on entry to SEND and on every fall. It counts in SEND, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES: clk_oe=0, dat_oe=0, err_code=10, done=1, err=1, busy=0, -> IDLE. This applies even if a nack was recorded.
  - This also covers a device that never starts clocking after RTS.
- Falls during IDLE, INHIBIT or RTS are ignored. This includes the self-induced edge when clk_oe asserts.
- The transmitter never drives a line high; release is dat_oe=0 / clk_oe=0 only.
- Device-to-host receive is out of scope. keyboard_tracker owns it; arbitration is at the top level.

Test Plan:
Bench parameters: INHIBIT_CYCLES=20, RTS_CYCLES=4, TIMEOUT_CYCLES=200. A device model clocks at 10-cycle half-periods and samples data on rising edges.
1. send with data=8'hED -> clk_oe high exactly 24 cycles. Device sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACKs low -> done=1, err=0, err_code=00, busy drops the same cycle.
2. data=8'h01 -> parity bit 0. data=8'hFF -> parity bit 1. Both acked, err_code=00.
3. NACK: device leaves dat high on clock 11 -> done=1, err=1, err_code=01, both oe 0.
4. Device never clocks -> exactly 200 cycles after entering SEND: done=1, err=1, err_code=10, clk_oe=0, dat_oe=0.
5. reset low during data bit 4 -> both oe 0 and busy 0 immediately. After release, send 8'hF4 completes with err_code=00.
6. send pulsed during INHIBIT -> ignored; exactly one done per accepted send. send in the cycle after done -> accepted, err_code cleared to 00.
